// File: rtl/m00_axis_pkg.sv
// Shared constants and output-stage state encoding for the AXI-Stream
// master and slave side FIFOs.
package m00_axis_pkg;

   localparam int DEF_TDATA_WIDTH  = 32;
   localparam int DEF_FIFO_DEPTH   = 16;
   localparam int DEF_AFULL_THRESH = 12;

   typedef enum logic {
      OUT_EMPTY = 1'b0,
      OUT_VALID = 1'b1
   } out_state_t;

endpackage

// File: rtl/m00_axis_mem.sv
// Simple dual-port storage: synchronous write, read data feeds the
// registered output stage in the top.
module m00_axis_mem
   import m00_axis_pkg::*;
#(
   parameter int W     = DEF_TDATA_WIDTH + 2,
   parameter int DEPTH = DEF_FIFO_DEPTH,
   localparam int AW   = $clog2(DEPTH)
)(
   input  logic          i_clk,
   input  logic          i_wr_en,
   input  logic [AW-1:0] i_wr_addr,
   input  logic [W-1:0]  i_wr_data,
   input  logic [AW-1:0] i_rd_addr,
   output logic [W-1:0]  o_rd_data
);

   logic [W-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_wr_en)
         r_mem[i_wr_addr] <= i_wr_data;
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/m00_axis.sv
// AXI-Stream master FIFO: storage memory plus one output register.
// Define M00_AXIS_ALMOST_FULL_EN to add the almost_full port.
module m00_axis
   import m00_axis_pkg::*;
#(
   parameter int C_M_AXIS_TDATA_WIDTH  = DEF_TDATA_WIDTH,
   parameter int C_M_AXIS_FIFO_DEPTH   = DEF_FIFO_DEPTH,
   parameter int C_M_AXIS_AFULL_THRESH = DEF_AFULL_THRESH
)(
   input  logic                              M_AXIS_ACLK,
   input  logic                              M_AXIS_ARESETN,
   input  logic                              wr_en,
   input  logic [C_M_AXIS_TDATA_WIDTH-1:0]   data_in,
   input  logic                              user_in,
   input  logic                              last_in,
   output logic                              full,
   output logic                              empty,
   output logic                              overflow,
`ifdef M00_AXIS_ALMOST_FULL_EN
   output logic                              almost_full,
`endif
   output logic                              M_AXIS_TVALID,
   input  logic                              M_AXIS_TREADY,
   output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
   output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
   output logic                              M_AXIS_TUSER,
   output logic                              M_AXIS_TLAST
);

   localparam int W  = C_M_AXIS_TDATA_WIDTH;
   localparam int AW = $clog2(C_M_AXIS_FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = W + 2;

   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_overflow;
   out_state_t    r_state;
   logic [W-1:0]  r_tdata;
   logic          r_tuser;
   logic          r_tlast;

   logic          w_full;
   logic          w_push;
   logic          w_pop;
   logic [EW-1:0] w_rd_data;

   assign w_full = (r_count == CW'(C_M_AXIS_FIFO_DEPTH));
   assign w_push = wr_en && !w_full;
   // Memory is read whenever the output register is free or being drained.
   assign w_pop  = (r_count != '0) &&
                   ((r_state == OUT_EMPTY) || M_AXIS_TREADY);

   m00_axis_mem #(
      .W     (EW),
      .DEPTH (C_M_AXIS_FIFO_DEPTH)
   ) u_mem (
      .i_clk     (M_AXIS_ACLK),
      .i_wr_en   (w_push),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data ({data_in, user_in, last_in}),
      .i_rd_addr (r_rd_ptr),
      .o_rd_data (w_rd_data)
   );

   always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
      if (!M_AXIS_ARESETN) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + AW'(1);
         if (wr_en && w_full)
            r_overflow <= 1'b1;
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
      if (!M_AXIS_ARESETN) begin
         r_state <= OUT_EMPTY;
         r_tdata <= '0;
         r_tuser <= 1'b0;
         r_tlast <= 1'b0;
      end else begin
         unique case (r_state)
            OUT_EMPTY: begin
               if (w_pop) begin
                  {r_tdata, r_tuser, r_tlast} <= w_rd_data;
                  r_state <= OUT_VALID;
               end
            end
            OUT_VALID: begin
               if (w_pop)
                  {r_tdata, r_tuser, r_tlast} <= w_rd_data;
               else if (M_AXIS_TREADY)
                  r_state <= OUT_EMPTY;
            end
            default: r_state <= OUT_EMPTY;
         endcase
      end
   end

   assign full          = w_full;
   assign empty         = (r_count == '0) && (r_state == OUT_EMPTY);
   assign overflow      = r_overflow;
   assign M_AXIS_TVALID = (r_state == OUT_VALID);
   assign M_AXIS_TDATA  = r_tdata;
   assign M_AXIS_TUSER  = r_tuser;
   assign M_AXIS_TLAST  = r_tlast;
   assign M_AXIS_TSTRB  = '1;

`ifdef M00_AXIS_ALMOST_FULL_EN
   assign almost_full = (r_count >= CW'(C_M_AXIS_AFULL_THRESH));
`endif

endmodule

// File: doc/m00_axis.md
M00_AXIS -- requirements
Module: m00_axis

Interface
REQ-001 Parameters SHALL be (name, default, meaning): C_M_AXIS_TDATA_WIDTH, 32, stream data width in bits (multiple of 8); C_M_AXIS_FIFO_DEPTH, 16, storage-memory entries (power of two, >=2); C_M_AXIS_AFULL_THRESH, 12, almost-full level.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- M_AXIS_ACLK  in  1  sole clock
- M_AXIS_ARESETN  in  1  asynchronous, active-low reset
- wr_en  in  1  push request from producing core
- data_in  in  C_M_AXIS_TDATA_WIDTH  push data
- user_in  in  1  start-of-frame tag
- last_in  in  1  end-of-line tag
- full  out  1  memory holds DEPTH entries
- empty  out  1  no word in memory or output register
- overflow  out  1  sticky: push attempted while full
- almost_full  out  1  present only with macro (REQ-015)
- M_AXIS_TVALID  out  1  output word valid
- M_AXIS_TREADY  in  1  downstream accepts
- M_AXIS_TDATA  out  C_M_AXIS_TDATA_WIDTH  output data
- M_AXIS_TSTRB  out  C_M_AXIS_TDATA_WIDTH/8  byte strobes
- M_AXIS_TUSER  out  1  output start-of-frame
- M_AXIS_TLAST  out  1  output end-of-line

Function
REQ-003 A push (wr_en=1, full=0) SHALL store {data_in,user_in,last_in} at wr_ptr and advance wr_ptr modulo DEPTH.
REQ-004 wr_en=1 with full=1 SHALL discard the word, leave pointers unchanged and set overflow until reset.
REQ-005 The block SHALL hold one output register (states OUT_EMPTY, OUT_VALID); M_AXIS_TVALID=1 exactly in OUT_VALID.
REQ-006 OUT_EMPTY->OUT_VALID SHALL occur when memory is non-empty, loading the entry at rd_ptr and advancing rd_ptr.
REQ-007 In OUT_VALID with TREADY=1: if memory non-empty, reload next entry and remain in OUT_VALID; else go to OUT_EMPTY.
REQ-008 In OUT_VALID with TREADY=0, TDATA/TUSER/TLAST SHALL be held stable and TVALID SHALL stay 1 (AXIS: no withdrawal).
REQ-009 Latency: a word pushed into an empty block at edge k SHALL appear with TVALID=1 after edge k+1; sustained throughput one word/cycle when wr_en and TREADY are both held high.
REQ-010 Simultaneous push and memory read SHALL leave the memory count unchanged; count width $clog2(DEPTH)+1, no wrap past DEPTH or below 0.
REQ-011 full SHALL be combinational from count (count==DEPTH); empty SHALL be 1 iff count==0 and state is OUT_EMPTY.
REQ-012 M_AXIS_TSTRB SHALL be all ones constantly.
REQ-013 Pointer wrap-around from DEPTH-1 to 0 SHALL be seamless with no lost or duplicated word.

Reset
REQ-014 Asserting M_AXIS_ARESETN low SHALL, asynchronously and even mid-transfer, clear pointers, count, overflow, state to OUT_EMPTY, TVALID/TDATA/TUSER/TLAST to 0; memory contents need not reset; full=0, empty=1 while in reset.

Configuration
REQ-015 With macro M00_AXIS_ALMOST_FULL_EN defined, almost_full port SHALL exist and equal (count >= C_M_AXIS_AFULL_THRESH); without it the port and its logic SHALL be absent and all other behaviour identical.

Structure
REQ-016 A shared package SHALL hold the out-stage state encoding (OUT_EMPTY=0, OUT_VALID=1) and default width/depth constants, shared with the slave-side FIFO.
REQ-017 Storage SHALL be one sub-module m00_axis_mem (simple dual-port, synchronous write, registered read path feeding the output register); control stays in the top.

Verification
REQ-018 Push 0x11,0x22,0x33 (TUSER on first, TLAST on third), TREADY=1 -> same three words out in order on consecutive cycles, tags aligned.
REQ-019 Push 0xA5 with TREADY=0 for 5 cycles -> TVALID=1, TDATA=0xA5 held all 5 cycles; accepted on first TREADY=1 cycle.
REQ-020 TREADY=0, push 18 words -> full=1 after memory holds 16 (one more in output register), 18th push drops, overflow=1; drain yields 17 words in order.
REQ-021 Continuous push and TREADY=1 for 40 words (2+ wraps) -> 40 words in order, count never exceeds 1, no TVALID gap after first word.
REQ-022 Assert reset with 5 words buffered and TVALID=1 -> TVALID=0, empty=1 immediately; post-reset push 0x77 emerges first.
REQ-023 With M00_AXIS_ALMOST_FULL_EN, TREADY=0, push 12 words into memory -> almost_full=1 at count 12, 0 at 11.
